lcd_i2c_encoder: RTL and testbench
==================================

// Module: lcd_i2c_encoder
// PURPOSE
//   Upstream feeder for the I2C command sequencer. Accepts one HD44780 LCD transfer (RS + byte)
//   and expands it into the 11-bit {cmd[2:0], data[7:0]} command-word stream for a PCF8574 backpack in 4-bit mode.
//   Generates the EN strobe pairs and START/address/STOP framing.
//   Optionally holds off the next transfer for slow LCD commands (clear, home).
// PARAMETERS
//   I2C_ADDR        7'h27    7-bit PCF8574 slave address; address byte = {I2C_ADDR, 1'b0}
//   CMD_START       3'd1     cmd code for START condition (data field 8'h00)
//   CMD_WRITE       3'd2     cmd code for byte write
//   CMD_STOP        3'd3     cmd code for STOP condition (data field 8'h00)
//   LONG_WAIT_CYC   20'd0    idle cycles inserted after STOP when lcd_long_wait was set; 0 = no wait
// PORTS
//   clk              in   1   system clock
//   reset            in   1   asynchronous, active-high reset
//   lcd_valid        in   1   transfer request
//   lcd_ready        out  1   encoder can accept a transfer (high only in IDLE)
//   lcd_rs           in   1   HD44780 RS (0 = instruction, 1 = data)
//   lcd_data         in   8   byte to send
//   lcd_nibble_only  in   1   send only lcd_data[7:4] (4-bit-mode init writes)
//   lcd_long_wait    in   1   insert LONG_WAIT_CYC after STOP
//   backlight        in   1   backpack P3 level for this transfer
//   cmd_valid        out  1   cmd_word valid toward sequencer
//   cmd_ready        in   1   sequencer accepts cmd_word
//   cmd_word         out  11  {cmd[2:0], data[7:0]}
//   busy             out  1   ~lcd_ready
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, lcd_ready=1, cmd_valid=0, cmd_word=0, busy=0, wait counter=0.
// - Capture: on lcd_valid & lcd_ready (cycle T), register rs, data, nibble_only, long_wait, backlight.
//   Inputs are ignored outside IDLE.
// - Expander byte: {nib[3:0], BL, EN, RW=0, RS} (P7..P0).
// - States and words (all outputs registered):
//   IDLE -> START (CMD_START,00) -> ADDR (CMD_WRITE,{I2C_ADDR,0}) -> HI_EN (nib=data[7:4],EN=1)
//   -> HI (EN=0) -> [LO_EN (nib=data[3:0],EN=1) -> LO (EN=0)] -> STOP (CMD_STOP,00) -> [WAIT] -> IDLE.
//   LO_EN/LO are skipped when nibble_only. WAIT is entered only when long_wait=1 and LONG_WAIT_CYC!=0.
// - Handshake: cmd_valid=1 in every state except IDLE/WAIT.
//   cmd_word is held stable until the cycle where cmd_valid & cmd_ready are both high.
//   The state advances on that cycle, and the next word is presented in the following cycle.
// - Latency: START word is valid at T+1. With cmd_ready tied high:
//   full transfer = 7 words (T+1..T+7), nibble-only = 5 words (T+1..T+5).
//   lcd_ready returns the cycle after the STOP handshake.
// - WAIT: on STOP handshake at cycle S, load counter = LONG_WAIT_CYC-1 and decrement each cycle.
//   Go to IDLE when counter==0, so lcd_ready=1 at S+1+LONG_WAIT_CYC. Counter is 20 bits and does not wrap.
// - cmd_ready high while cmd_valid low: no effect. lcd_valid high outside IDLE: no effect; data is not queued.
// - Reset mid-stream: sequence is abandoned with no STOP emitted. The downstream sequencer is reset on the same net.
// - Any illegal state encoding: next state = IDLE with cmd_valid=0.
// TESTING
// - Reset during ADDR with cmd_valid=1 -> cmd_valid=0, lcd_ready=1 immediately, no further words.
// - rs=1, data=8'h41, bl=1, cmd_ready=1 -> words 0x100,0x24E,0x24D,0x249,0x21D,0x219,0x300;
//   lcd_ready=1 at T+8.
// - nibble_only=1, rs=0, data=8'h30, bl=0 -> 0x100,0x24E,0x234,0x230,0x300; lcd_ready at T+6.
// - cmd_ready held low 10 cycles on HI_EN -> cmd_word stays 0x24D, cmd_valid stays 1; advances after one ready cycle.
// - LONG_WAIT_CYC=16, long_wait=1, data=8'h01 -> after STOP at S, lcd_ready low until S+17.
//   lcd_valid pulses during WAIT are dropped.
// - Back-to-back lcd_valid held high -> second transfer captured the cycle lcd_ready rises.
//   Its START follows with no dropped or duplicated words.

Source files
------------

// File: rtl/lcd_i2c_encoder.sv
// Expands one HD44780 transfer (RS + byte) into the PCF8574 4-bit-mode command-word stream
// {cmd[2:0], data[7:0]} with START/address/STOP framing and an optional post-STOP hold-off.
module lcd_i2c_encoder #(
  parameter logic [6:0]  I2C_ADDR      = 7'h27,
  parameter logic [2:0]  CMD_START     = 3'd1,
  parameter logic [2:0]  CMD_WRITE     = 3'd2,
  parameter logic [2:0]  CMD_STOP      = 3'd3,
  parameter logic [19:0] LONG_WAIT_CYC = 20'd0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        lcd_valid_i,
  output logic        lcd_ready_o,
  input  logic        lcd_rs_i,
  input  logic [7:0]  lcd_data_i,
  input  logic        lcd_nibble_only_i,
  input  logic        lcd_long_wait_i,
  input  logic        backlight_i,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [10:0] cmd_word_o,
  output logic        busy_o
);

  typedef enum logic [3:0] {
    StIdle, StStart, StAddr, StHiEn, StHi, StLoEn, StLo, StStop, StWait
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        rs_q, nib_q, lw_q, bl_q;
  logic [7:0]  data_q;
  logic        capture;
  logic        accept;
  logic        valid_q, valid_d;
  logic        ready_q, ready_d;
  logic [10:0] word_q, word_d;

  assign accept = valid_q & cmd_ready_i;

  // Backpack pin map P7..P0: {D7..D4, BL, EN, RW, RS}.
  function automatic logic [7:0] exp_byte(input logic [3:0] nib, input logic en,
                                          input logic bl, input logic rs);
    return {nib, bl, en, 1'b0, rs};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        if (lcd_valid_i) begin
          capture = 1'b1;
          state_d = StStart;
        end
      end
      StStart: if (accept) state_d = StAddr;
      StAddr:  if (accept) state_d = StHiEn;
      StHiEn:  if (accept) state_d = StHi;
      StHi:    if (accept) state_d = nib_q ? StStop : StLoEn;
      StLoEn:  if (accept) state_d = StLo;
      StLo:    if (accept) state_d = StStop;
      StStop: begin
        if (accept) begin
          if (lw_q && (LONG_WAIT_CYC != 20'd0)) begin
            state_d = StWait;
            cnt_d   = LONG_WAIT_CYC - 20'd1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StWait: begin
        if (cnt_q == 20'd0) state_d = StIdle;
        else                cnt_d   = cnt_q - 20'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    word_d  = 11'd0;
    valid_d = 1'b1;
    ready_d = (state_d == StIdle);
    case (state_d)
      StStart: word_d = {CMD_START, 8'h00};
      StAddr:  word_d = {CMD_WRITE, I2C_ADDR, 1'b0};
      StHiEn:  word_d = {CMD_WRITE, exp_byte(data_q[7:4], 1'b1, bl_q, rs_q)};
      StHi:    word_d = {CMD_WRITE, exp_byte(data_q[7:4], 1'b0, bl_q, rs_q)};
      StLoEn:  word_d = {CMD_WRITE, exp_byte(data_q[3:0], 1'b1, bl_q, rs_q)};
      StLo:    word_d = {CMD_WRITE, exp_byte(data_q[3:0], 1'b0, bl_q, rs_q)};
      StStop:  word_d = {CMD_STOP, 8'h00};
      default: valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= 20'd0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      word_q  <= 11'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      word_q  <= word_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rs_q   <= 1'b0;
      data_q <= 8'h00;
      nib_q  <= 1'b0;
      lw_q   <= 1'b0;
      bl_q   <= 1'b0;
    end else if (capture) begin
      rs_q   <= lcd_rs_i;
      data_q <= lcd_data_i;
      nib_q  <= lcd_nibble_only_i;
      lw_q   <= lcd_long_wait_i;
      bl_q   <= backlight_i;
    end
  end

  assign lcd_ready_o = ready_q;
  assign busy_o      = ~ready_q;
  assign cmd_valid_o = valid_q;
  assign cmd_word_o  = word_q;

endmodule

// File: tb/tb_lcd_i2c_encoder.sv
// Scoreboard bench for lcd_i2c_encoder: stimulus queues expected words and point checks,
// a negedge monitor compares every accepted cmd_word and every queued check.
module tb_lcd_i2c_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        lcd_valid, lcd_rs, lcd_nib, lcd_lw, bl, cmd_ready;
  logic [7:0]  lcd_data;
  logic        lcd_ready, cmd_valid, busy;
  logic [10:0] cmd_word;

  lcd_i2c_encoder #(
    .LONG_WAIT_CYC(20'd16)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .lcd_valid_i       (lcd_valid),
    .lcd_ready_o       (lcd_ready),
    .lcd_rs_i          (lcd_rs),
    .lcd_data_i        (lcd_data),
    .lcd_nibble_only_i (lcd_nib),
    .lcd_long_wait_i   (lcd_lw),
    .backlight_i       (bl),
    .cmd_valid_o       (cmd_valid),
    .cmd_ready_i       (cmd_ready),
    .cmd_word_o        (cmd_word),
    .busy_o            (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  logic [10:0] exp_q[$];
  chk_t        chk_q[$];
  int          total = 0;
  int          bad = 0;

  always @(negedge clk) begin : monitor
    chk_t        c;
    logic [10:0] e;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      total++;
      if (c.act !== c.exp) begin
        bad++;
        $display("FAIL %s: got %0h want %0h", c.name, c.act, c.exp);
      end
    end
    if (!reset && cmd_valid && cmd_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_word: got %03h want none", cmd_word);
      end else begin
        e = exp_q.pop_front();
        if (cmd_word !== e) begin
          bad++;
          $display("FAIL cmd_word: got %03h want %03h", cmd_word, e);
        end
      end
    end
  end

  task automatic push(input string n, input logic [31:0] a, input logic [31:0] e);
    chk_t t;
    t.name = n;
    t.act  = a;
    t.exp  = e;
    chk_q.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic rs, input logic [7:0] d, input logic nib,
                        input logic lw, input logic b);
    lcd_rs   = rs;
    lcd_data = d;
    lcd_nib  = nib;
    lcd_lw   = lw;
    bl       = b;
  endtask

  // Returns one cycle after the capture edge (the cycle START is presented).
  task automatic start_xfer(input logic rs, input logic [7:0] d, input logic nib,
                            input logic lw, input logic b);
    set_in(rs, d, nib, lw, b);
    lcd_valid = 1'b1;
    tick();
    lcd_valid = 1'b0;
  endtask

  task automatic wait_ready(input string n, input int budget);
    int k = 0;
    while (!lcd_ready && k < budget) begin
      tick();
      k++;
    end
    push(n, 32'(lcd_ready), 32'd1);
  endtask

  task automatic push_words(input logic [10:0] w[]);
    foreach (w[i]) exp_q.push_back(w[i]);
  endtask

  initial begin
    reset     = 1'b1;
    lcd_valid = 1'b0;
    cmd_ready = 1'b0;
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #12;
    push("rst_ready", 32'(lcd_ready), 32'd1);
    push("rst_busy", 32'(busy), 32'd0);
    push("rst_valid", 32'(cmd_valid), 32'd0);
    push("rst_word", 32'(cmd_word), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Full transfer, rs=1 data=41 bl=1
    cmd_ready = 1'b1;
    push_words('{11'h100, 11'h24E, 11'h24D, 11'h249, 11'h21D, 11'h219, 11'h300});
    start_xfer(1'b1, 8'h41, 1'b0, 1'b0, 1'b1);
    push("full_start_valid", 32'(cmd_valid), 32'd1);
    repeat (6) tick();
    push("full_ready_T7", 32'(lcd_ready), 32'd0);
    tick();
    push("full_ready_T8", 32'(lcd_ready), 32'd1);
    push("full_busy_T8", 32'(busy), 32'd0);
    tick();

    // Nibble-only, rs=0 data=30 bl=0
    push_words('{11'h100, 11'h24E, 11'h234, 11'h230, 11'h300});
    start_xfer(1'b0, 8'h30, 1'b1, 1'b0, 1'b0);
    repeat (4) tick();
    push("nib_ready_T5", 32'(lcd_ready), 32'd0);
    tick();
    push("nib_ready_T6", 32'(lcd_ready), 32'd1);
    tick();

    // Backpressure on HI_EN
    push_words('{11'h100, 11'h24E, 11'h24D, 11'h249, 11'h21D, 11'h219, 11'h300});
    start_xfer(1'b1, 8'h41, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    cmd_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      push("hold_word", 32'(cmd_word), 32'h24D);
      push("hold_valid", 32'(cmd_valid), 32'd1);
    end
    cmd_ready = 1'b1;
    tick();
    push("hold_advance", 32'(cmd_word), 32'h249);
    wait_ready("hold_ready_timeout", 20);
    tick();

    // Long wait, data=01 rs=0 bl=1; lcd_valid pulses in WAIT are dropped
    push_words('{11'h100, 11'h24E, 11'h20C, 11'h208, 11'h21C, 11'h218, 11'h300});
    start_xfer(1'b0, 8'h01, 1'b0, 1'b1, 1'b1);
    repeat (6) tick();
    push("wait_stop_word", 32'(cmd_word), 32'h300);
    repeat (3) tick();
    set_in(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    lcd_valid = 1'b1;
    tick();
    push("wait_valid_low", 32'(cmd_valid), 32'd0);
    tick();
    lcd_valid = 1'b0;
    repeat (11) tick();
    push("wait_ready_S16", 32'(lcd_ready), 32'd0);
    push("wait_busy_S16", 32'(busy), 32'd1);
    tick();
    push("wait_ready_S17", 32'(lcd_ready), 32'd1);
    repeat (3) tick();

    // Back-to-back with lcd_valid held high
    push_words('{11'h100, 11'h24E, 11'h24D, 11'h249, 11'h21D, 11'h219, 11'h300,
                 11'h100, 11'h24E, 11'h234, 11'h230, 11'h300});
    set_in(1'b1, 8'h41, 1'b0, 1'b0, 1'b1);
    lcd_valid = 1'b1;
    tick();
    set_in(1'b0, 8'h30, 1'b1, 1'b0, 1'b0);
    repeat (6) tick();
    push("b2b_ready_T7", 32'(lcd_ready), 32'd0);
    tick();
    push("b2b_ready_T8", 32'(lcd_ready), 32'd1);
    tick();
    lcd_valid = 1'b0;
    push("b2b_second_start", 32'(cmd_word), 32'h100);
    push("b2b_second_ready", 32'(lcd_ready), 32'd0);
    wait_ready("b2b_ready_timeout", 20);
    tick();

    // Reset while ADDR is presented and stalled
    cmd_ready = 1'b0;
    exp_q.push_back(11'h100);
    start_xfer(1'b1, 8'h41, 1'b0, 1'b0, 1'b1);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    push("rstmid_addr_word", 32'(cmd_word), 32'h24E);
    #2;
    reset = 1'b1;
    #1;
    push("rstmid_valid", 32'(cmd_valid), 32'd0);
    push("rstmid_ready", 32'(lcd_ready), 32'd1);
    push("rstmid_word", 32'(cmd_word), 32'd0);
    tick();
    reset = 1'b0;
    cmd_ready = 1'b1;
    repeat (6) tick();
    push("rstmid_idle", 32'(lcd_ready), 32'd1);

    tick();
    push("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
